// File: rtl/ssi_pkg.sv
// Shared FSM states, BCD digit constants and display-range helper for the BCD controller.
package ssi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Largest value representable on n decimal digits: 10^n - 1.
    function automatic logic [31:0] max_display(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/ssi_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more (4-bit, carry dropped).
// Purely combinational; no handshake.
module ssi_bcd_add3
    import ssi_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= ADD3_THRESHOLD) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/ssi_bcd_controller.sv
// Binary-to-BCD display controller: latency BIN_WIDTH+1 cycles from load to o_done; loads are dropped while o_busy.
// Optional leading-zero blanking output o_blank under SSI_LEADING_ZERO_BLANK_EN.
module ssi_bcd_controller
    import ssi_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [BIN_WIDTH-1:0]              i_value,
    input  logic                              i_load,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overflow,
`ifdef SSI_LEADING_ZERO_BLANK_EN
    output logic [NUM_DIGITS-1:0]             o_blank,
`endif
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] o_digits
);

    localparam int          SW      = BCD_DIGIT_W * NUM_DIGITS;
    localparam int          CW      = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = max_display(NUM_DIGITS);
    localparam logic [SW-1:0] NINES = {NUM_DIGITS{4'h9}};

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic [BIN_WIDTH-1:0] shreg;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        adj;
    logic [CW-1:0]        cnt;
    logic                 ovf_flag;
    logic                 ovf_in;

    assign ovf_in = (32'(i_value) > MAX_VAL);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        ssi_bcd_add3 u_add3 (
            .digit    (scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .adjusted (adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (i_load) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SSI_LEADING_ZERO_BLANK_EN
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  hi_zero;

    // Digit k blanks only when it and every more significant digit are zero.
    always_comb begin
        blank_c = '0;
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            hi_zero    = hi_zero & (scratch[BCD_DIGIT_W*k +: BCD_DIGIT_W] == 4'd0);
            blank_c[k] = hi_zero;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shreg      <= '0;
            scratch    <= '0;
            cnt        <= '0;
            ovf_flag   <= 1'b0;
            o_digits   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
`ifdef SSI_LEADING_ZERO_BLANK_EN
            o_blank    <= BLANK_RST;
`endif
        end else begin
            o_busy <= (state_nxt != IDLE);
            o_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= i_value;
                        scratch  <= '0;
                        cnt      <= CW'(BIN_WIDTH);
                        ovf_flag <= ovf_in;
                    end
                end
                SHIFT: begin
                    // Bits leaving the top of scratch only occur on overflow, which saturates anyway.
                    {scratch, shreg} <= {adj, shreg} << 1;
                    cnt              <= cnt - CW'(1);
                end
                DONE: begin
                    o_digits   <= ovf_flag ? NINES : scratch;
                    o_overflow <= ovf_flag;
`ifdef SSI_LEADING_ZERO_BLANK_EN
                    o_blank    <= ovf_flag ? '0 : blank_c;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssi_bcd_controller.sv
// Randomized self-checking bench for ssi_bcd_controller against a div/mod decimal reference model.
module tb_ssi_bcd_controller;

    localparam int ND   = 4;
    localparam int BW   = 14;
    localparam int MAXV = 10 ** ND - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load = 1'b0;
    logic [BW-1:0]   value = '0;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [4*ND-1:0] digits;
`ifdef SSI_LEADING_ZERO_BLANK_EN
    logic [ND-1:0]   blank;
`endif

    int checks = 0;
    int errors = 0;

    ssi_bcd_controller #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_value    (value),
        .i_load     (load),
        .o_busy     (busy),
        .o_done     (done),
        .o_overflow (ovf),
`ifdef SSI_LEADING_ZERO_BLANK_EN
        .o_blank    (blank),
`endif
        .o_digits   (digits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*ND-1:0] ref_digits(input int v);
        logic [4*ND-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = (v > MAXV) ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [ND-1:0] ref_blank(input int v);
        logic [ND-1:0] b;
        b = '0;
        if (v <= MAXV) begin
            for (int k = 1; k < ND; k++) begin
                b[k] = (v < 10 ** k);
            end
        end
        return b;
    endfunction

    // Caller is one step past a rising edge. jN = edge index E_k at which a stray load of junk is driven.
    task automatic do_conv(input int v, input int j1, input int j2, input int junk);
        logic [4*ND-1:0] held;
        int  lat;
        bit  moved;
        bit  dropped;
        value = BW'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        value = BW'($urandom);
        chk("busy_e0", busy, 1);
        chk("done_low_e0", done, 0);
        held    = digits;
        lat     = 0;
        moved   = 1'b0;
        dropped = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == j1 || k == j2) begin
                load  = 1'b1;
                value = BW'(junk);
            end else begin
                load  = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (digits !== held) moved = 1'b1;
            if (busy !== 1'b1) dropped = 1'b1;
        end
        load = 1'b0;
        chk("latency", lat, BW + 1);
        chk("digits_hold", moved, 0);
        chk("busy_held", dropped, 0);
        chk("digits", digits, ref_digits(v));
        chk("overflow", ovf, (v > MAXV) ? 1 : 0);
        chk("busy_after", busy, 0);
`ifdef SSI_LEADING_ZERO_BLANK_EN
        chk("blank", blank, ref_blank(v));
`endif
    endtask

    initial begin
        int seen;
        int v;
        int j1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", digits, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
`ifdef SSI_LEADING_ZERO_BLANK_EN
        chk("rst_blank", blank, 4'b1110);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        do_conv(1234, 0, 0, 0);
        do_conv(10000, 0, 0, 0);
        do_conv(7, 0, 0, 0);
        do_conv(42, 5, 15, 999);
        do_conv(999, 0, 0, 0);
        do_conv(0, 0, 0, 0);
        do_conv(9999, 0, 0, 0);
        do_conv(16383, 0, 0, 0);

        // Abort at E7 of a conversion; reset acts without a clock edge.
        value = BW'(5678);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_digits", digits, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
`ifdef SSI_LEADING_ZERO_BLANK_EN
        chk("abort_blank", blank, 4'b1110);
`endif
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_quiet", seen, 0);
        do_conv(5678, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            j1 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BW + 1) : 0;
            do_conv(v, j1, 0, $urandom_range(0, 16383));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssi_bcd_controller.md
Name: ssi_bcd_controller

Overview:
- Sequences the per-digit seven-segment encoders on a multi-digit display.
- Accepts a binary value (e.g. BPM from the metronome core) through a load/busy handshake.
- Converts the value to BCD with a sequential shift-add-3 (double-dabble) FSM.
- Presents one registered 4-bit digit per display position, to feed the i_digit input of each seven-segment encoder instance.

Parameters:
- NUM_DIGITS, 4, number of BCD digits/displays driven (1..6)
- BIN_WIDTH, 14, width of binary input value (1..20)

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous active-high reset
- i_value  input  BIN_WIDTH  binary value to display
- i_load  input  1  request conversion of i_value; accepted only when o_busy=0
- o_busy  output  1  conversion in progress; new loads ignored
- o_done  output  1  one-cycle pulse when o_digits updated
- o_overflow  output  1  last accepted value exceeded 10^NUM_DIGITS-1
- o_digits  output  4*NUM_DIGITS  BCD digits; digit k at [4k+3:4k], k=0 is least significant

Behaviour:
- Interface: one clock; reset is asynchronous and active-high on i_reset; all outputs registered on posedge i_clk.
- Reset values: o_digits=0 (all digits 0), o_busy=0, o_done=0, o_overflow=0, state=IDLE, scratch registers 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - if i_load=1 at edge E0: latch i_value into shift register; clear BCD scratch; load bit counter=BIN_WIDTH; go SHIFT; o_busy=1 from E0.
  - Also latch overflow flag = (i_value > 10^NUM_DIGITS-1).
- SHIFT, one bit per cycle:
  - Every scratch digit >=5 gets +3 (4-bit, no carry out).
  - Then {scratch, shift} shifts left by 1; counter decrements.
  - When counter reaches 1 at a SHIFT edge, go DONE. Exactly BIN_WIDTH SHIFT edges: E1..E_BIN_WIDTH.
- DONE, edge E_{BIN_WIDTH+1}:
  - o_digits <= scratch, or all digits 9 if the overflow flag is set (saturate).
  - o_overflow <= flag; o_done=1 for that cycle only; o_busy=0; go IDLE.
- Latency: load edge to o_done/o_digits update = BIN_WIDTH+1 cycles. Throughput: one conversion per BIN_WIDTH+2 cycles.
- o_digits holds its last value throughout a conversion; the display never shows partial results.
- Loads are dropped (not queued) when i_load=1 while o_busy=1, including the DONE cycle; i_value changes during conversion have no effect.
- Scratch digit width: 4*NUM_DIGITS bits; bits shifted out of the top are discarded (only reachable in the overflow case, which is masked by saturation).
- Reset asserted mid-SHIFT or in DONE: immediate abort; outputs to reset values; no o_done pulse; o_overflow cleared.
- BIN_WIDTH too small to exceed 10^NUM_DIGITS-1: overflow compare is constant 0; no special handling.

Optional Feature:
- Macro SSI_LEADING_ZERO_BLANK_EN.
- Defined: adds output o_blank [NUM_DIGITS-1:0], registered and updated together with o_digits.
  - o_blank[k]=1 when digit k and all higher digits are 0, for k>=1; o_blank[0] is always 0.
  - Reset value is all ones except bit 0.
  - On overflow, o_blank=0.
  - The board top uses o_blank to force segments off.
- Undefined: port and logic absent; all digits always shown, including leading zeros.

Decomposition:
- Package ssi_pkg: state encoding constants (IDLE/SHIFT/DONE), BCD_DIGIT_W=4, ADD3_THRESHOLD=5, and a constant function for max displayable value 10^n-1.
- Sub-module ssi_bcd_add3: combinational 4-bit cell, out = (in>=5) ? in+3 : in. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset with defaults -> o_digits=16'h0000, o_busy=0, o_done=0, o_overflow=0; with macro, o_blank=4'b1110.
- Load 1234 at E0 -> o_busy high for 15 cycles; o_done single pulse at E15; o_digits=16'h1234; o_overflow=0.
- Load 10000 (BIN_WIDTH=14) -> o_digits=16'h9999, o_overflow=1. A following load of 7 -> 16'h0007, o_overflow=0, and with macro o_blank=4'b1110.
- Load 42, then pulse i_load with value 999 at E5 and at E15 (DONE) -> both ignored; o_digits=16'h0042. A load of 999 at E16 is accepted -> 16'h0999, with macro o_blank=4'b1000.
- Load 5678, assert i_reset at E7 -> outputs return to reset values asynchronously; no o_done pulse; a subsequent load of 5678 completes normally -> 16'h5678.
- Load 0 and load 9999 -> 16'h0000 and 16'h9999; exhaustive sweep 0..9999 compared against a reference model (div/mod by 10).
